// File: rtl/clock_display_scan_if.sv
// +----------------------------------------------------------------------------+
// | clock_display_scan_if                                                      |
// | Time fields into, and multiplexed 7-segment drive out of, the display scan.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface clock_display_scan_if;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  // master: the time source / observer side
  modport master (
    output sec, min, hour,
    input  an, seg, dp, frame_start
  );

  // slave: the display scanner
  modport slave (
    input  sec, min, hour,
    output an, seg, dp, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/clock_display_scan.sv
// +----------------------------------------------------------------------------+
// | clock_display_scan                                                         |
// | Frame-snapshotted hh:mm:ss to 6-digit multiplexed 7-segment driver with    |
// | anti-ghost blanking. Optional macro LZ_BLANK_EN blanks a leading hour zero.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module clock_display_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  clock_display_scan_if.slave  disp
);

  localparam int              PW           = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   c_pre_last   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]   c_pre_one    = PW'(1);
  localparam logic [2:0]      c_digit_last = 3'd5;
  localparam logic [6:0]      c_seg_dash   = 7'h40;
  localparam logic [6:0]      c_seg_off    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [5:0]      c_an_off     = AN_ACTIVE_LOW ? 6'h3F : 6'h00;
  localparam logic            c_dp_off     = SEG_ACTIVE_LOW;

  logic [PW-1:0] r_pre;
  logic [2:0]    r_digit;
  logic [5:0]    r_sec_sh;
  logic [5:0]    r_min_sh;
  logic [4:0]    r_hour_sh;
  logic          r_frame_start;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_tick;
  logic          w_frame_end;
  logic          w_blank;
  logic          w_lz_dark;
  logic          w_dark;
  logic [7:0]    w_sec_bcd;
  logic [7:0]    w_min_bcd;
  logic [7:0]    w_hour_bcd;
  logic          w_sec_bad;
  logic          w_min_bad;
  logic          w_hour_bad;
  logic [3:0]    w_digit_val;
  logic          w_field_bad;
  logic [6:0]    w_seg_hi;
  logic          w_dp_hi;
  logic [5:0]    w_an_hi;

  // Returns {tens, units}. The units subtraction runs in 4 bits: the true
  // result is below 10, so the low nibbles of v and 10*tens suffice.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] sub;
    if (v >= 6'd50) begin
      tens = 4'd5; sub = 4'd2;
    end else if (v >= 6'd40) begin
      tens = 4'd4; sub = 4'd8;
    end else if (v >= 6'd30) begin
      tens = 4'd3; sub = 4'd14;
    end else if (v >= 6'd20) begin
      tens = 4'd2; sub = 4'd4;
    end else if (v >= 6'd10) begin
      tens = 4'd1; sub = 4'd10;
    end else begin
      tens = 4'd0; sub = 4'd0;
    end
    return {tens, v[3:0] - sub};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return c_seg_dash;
    endcase
  endfunction

  assign w_tick      = (r_pre == c_pre_last);
  assign w_frame_end = w_tick && (r_digit == c_digit_last);

  generate
    if (BLANK_CYC > 0) begin : g_blank
      localparam logic [PW-1:0] c_blank_cyc = PW'(BLANK_CYC);
      assign w_blank = (r_pre < c_blank_cyc);
    end else begin : g_no_blank
      assign w_blank = 1'b0;
    end
  endgenerate

`ifdef LZ_BLANK_EN
  assign w_lz_dark = (r_digit == c_digit_last) && (r_hour_sh < 5'd10);
`else
  assign w_lz_dark = 1'b0;
`endif

  assign w_dark = w_blank || w_lz_dark;

  // Scan timing and frame snapshot
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pre         <= '0;
      r_digit       <= 3'd0;
      r_sec_sh      <= 6'd0;
      r_min_sh      <= 6'd0;
      r_hour_sh     <= 5'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_pre         <= w_tick ? '0 : r_pre + c_pre_one;
      r_frame_start <= w_frame_end;
      if (w_tick) begin
        r_digit <= w_frame_end ? 3'd0 : r_digit + 3'd1;
      end
      if (w_frame_end) begin
        r_sec_sh  <= disp.sec;
        r_min_sh  <= disp.min;
        r_hour_sh <= disp.hour;
      end
    end
  end

  assign w_sec_bcd  = to_bcd(r_sec_sh);
  assign w_min_bcd  = to_bcd(r_min_sh);
  assign w_hour_bcd = to_bcd({1'b0, r_hour_sh});
  assign w_sec_bad  = (r_sec_sh > 6'd59);
  assign w_min_bad  = (r_min_sh > 6'd59);
  assign w_hour_bad = (r_hour_sh > 5'd23);

  always_comb begin
    w_digit_val = 4'd0;
    w_field_bad = 1'b0;
    case (r_digit)
      3'd0: begin w_digit_val = w_sec_bcd[3:0];  w_field_bad = w_sec_bad;  end
      3'd1: begin w_digit_val = w_sec_bcd[7:4];  w_field_bad = w_sec_bad;  end
      3'd2: begin w_digit_val = w_min_bcd[3:0];  w_field_bad = w_min_bad;  end
      3'd3: begin w_digit_val = w_min_bcd[7:4];  w_field_bad = w_min_bad;  end
      3'd4: begin w_digit_val = w_hour_bcd[3:0]; w_field_bad = w_hour_bad; end
      3'd5: begin w_digit_val = w_hour_bcd[7:4]; w_field_bad = w_hour_bad; end
      default: begin w_digit_val = 4'd0; w_field_bad = 1'b1; end
    endcase
  end

  assign w_seg_hi = w_field_bad ? c_seg_dash : seg_code(w_digit_val);
  assign w_dp_hi  = (r_digit == 3'd2) || (r_digit == 3'd4);
  assign w_an_hi  = 6'd1 << r_digit;

  // Registered drive; XOR with the "off" pattern applies polarity
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_an  <= c_an_off;
      r_seg <= c_seg_off;
      r_dp  <= c_dp_off;
    end else if (w_dark) begin
      r_an  <= c_an_off;
      r_seg <= c_seg_off;
      r_dp  <= c_dp_off;
    end else begin
      r_an  <= w_an_hi ^ c_an_off;
      r_seg <= w_seg_hi ^ c_seg_off;
      r_dp  <= w_dp_hi ^ c_dp_off;
    end
  end

  assign disp.an          = r_an;
  assign disp.seg         = r_seg;
  assign disp.dp          = r_dp;
  assign disp.frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_clock_display_scan.sv
// +----------------------------------------------------------------------------+
// | tb_clock_display_scan                                                      |
// | Directed self-checking bench, SCAN_DIV=4, BLANK_CYC=1, active-low drive.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_clock_display_scan;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   ok;
  int   cnt;

  logic [5:0] cap_an  [6];
  logic [6:0] cap_seg [6];
  logic       cap_dp  [6];
  logic [5:0] cap_blank_an;
  logic       cap_fs_next;

  clock_display_scan_if bus ();

  clock_display_scan #(
    .SCAN_DIV       (4),
    .BLANK_CYC      (1),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .disp  (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fs(output bit found);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clock);
      if (bus.frame_start === 1'b1) found = 1'b1;
    end
  endtask

  // Digit d of the frame is lit 4*d+2 negedges after the frame_start sample
  task automatic capture_frame();
    bit f;
    wait_fs(f);
    check("fs_seen", 32'(f), 32'd1);
    @(negedge clock);
    cap_blank_an = bus.an;
    cap_fs_next  = bus.frame_start;
    @(negedge clock);
    for (int d = 0; d < 6; d++) begin
      cap_an[d]  = bus.an;
      cap_seg[d] = bus.seg;
      cap_dp[d]  = bus.dp;
      if (d < 5) repeat (4) @(negedge clock);
    end
  endtask

  task automatic check_frame(input string name, input logic [41:0] exp_seg, input bit lz_dark);
    logic [5:0] exp_an;
    logic       exp_dp;
    check({name, "_blank_an"}, 32'(cap_blank_an), 32'h3F);
    check({name, "_fs_pulse"}, 32'(cap_fs_next), 32'd0);
    for (int d = 0; d < 6; d++) begin
      exp_an = ~(6'd1 << d);
      exp_dp = !(d == 2 || d == 4);
      if (lz_dark && d == 5) begin
        exp_an = 6'h3F;
        exp_dp = 1'b1;
      end
      check($sformatf("%s_an%0d", name, d), 32'(cap_an[d]), 32'(exp_an));
      check($sformatf("%s_seg%0d", name, d), 32'(cap_seg[d]), 32'(exp_seg[d*7 +: 7]));
      check($sformatf("%s_dp%0d", name, d), 32'(cap_dp[d]), 32'(exp_dp));
    end
  endtask

  initial begin
    bus.sec  = 6'd0;
    bus.min  = 6'd0;
    bus.hour = 5'd0;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_an", 32'(bus.an), 32'h3F);
    check("rst_seg", 32'(bus.seg), 32'h7F);
    check("rst_dp", 32'(bus.dp), 32'd1);
    check("rst_fs", 32'(bus.frame_start), 32'd0);

    bus.hour = 5'd13;
    bus.min  = 6'd45;
    bus.sec  = 6'd7;
    reset    = 1'b1;
    @(negedge clock);
    check("first_blank_an", 32'(bus.an), 32'h3F);
    @(negedge clock);
    check("first_d0_an", 32'(bus.an), 32'h3E);
    check("first_d0_seg", 32'(bus.seg), 32'h40);

    // 13:45:07 -> digits 7,0,5,4,3,1
    capture_frame();
    check_frame("hms", {7'h79, 7'h30, 7'h19, 7'h12, 7'h40, 7'h78}, 1'b0);

    // Frame period
    wait_fs(ok);
    check("fs_before_period", 32'(ok), 32'd1);
    cnt = 0;
    ok  = 1'b0;
    while (!ok && cnt < 100) begin
      @(negedge clock);
      cnt++;
      if (bus.frame_start === 1'b1) ok = 1'b1;
    end
    check("fs_period", 32'(cnt), 32'd24);

    // Change sec right after the snapshot: the running frame still shows 07
    bus.sec = 6'd8;
    repeat (2) @(negedge clock);
    check("hold_d0_seg", 32'(bus.seg), 32'h78);
    repeat (4) @(negedge clock);
    check("hold_d1_seg", 32'(bus.seg), 32'h40);
    repeat (4) @(negedge clock);
    check("hold_d2_an", 32'(bus.an), 32'h3B);
    capture_frame();
    check_frame("sec8", {7'h79, 7'h30, 7'h19, 7'h12, 7'h40, 7'h00}, 1'b0);

    // sec out of range -> dash on digits 0/1 only
    bus.sec  = 6'd60;
    bus.min  = 6'd59;
    bus.hour = 5'd23;
    capture_frame();
    check_frame("dash", {7'h24, 7'h30, 7'h12, 7'h10, 7'h3F, 7'h3F}, 1'b0);

    // hour 5: leading zero on digit 5 depends on build
    bus.sec  = 6'd0;
    bus.min  = 6'd0;
    bus.hour = 5'd5;
    capture_frame();
`ifdef LZ_BLANK_EN
    check_frame("lz", {7'h7F, 7'h12, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b1);
`else
    check_frame("lz", {7'h40, 7'h12, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);
`endif

    // Asynchronous reset while digit 3 is lit
    wait_fs(ok);
    check("fs_before_reset", 32'(ok), 32'd1);
    repeat (15) @(negedge clock);
    check("d3_lit_an", 32'(bus.an), 32'h37);
    #2 reset = 1'b0;
    #1;
    check("async_an", 32'(bus.an), 32'h3F);
    check("async_seg", 32'(bus.seg), 32'h7F);
    check("async_dp", 32'(bus.dp), 32'd1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("restart_blank_an", 32'(bus.an), 32'h3F);
    @(negedge clock);
    check("restart_d0_an", 32'(bus.an), 32'h3E);
    check("restart_d0_seg", 32'(bus.seg), 32'h40);
    repeat (16) @(negedge clock);
    check("restart_d4_an", 32'(bus.an), 32'h2F);
    check("restart_d4_seg", 32'(bus.seg), 32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
